regbank_sync: RTL
=================

Name: regbank_sync

Overview:
- Clocked, parametrised successor to the team's combinational register bank.
- Provides one synchronous write port and two registered read ports.
- On reset (or on request) a built-in sequencer clears every entry one per cycle; a ready flag reports when the clear is finished.
- Sits between decode and ALU in the datapath; replaces the latch-inferring, file-initialised bank.

Parameters:
- DATA_W, 32, width of each register and of all data ports.
- ADDR_W, 5, width of the address ports.
- DEPTH, 32, number of implemented entries; must satisfy DEPTH <= 2**ADDR_W.
- ZERO_REG, 1, when 1, entry 0 reads as zero and writes to it are discarded.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  starts a new clear sequence; sampled only in RUN.
- wr_en  input  1  write strobe.
- wr_addr  input  ADDR_W  write address.
- wr_data  input  DATA_W  write data.
- rd_addr1  input  ADDR_W  read port 1 address.
- rd_addr2  input  ADDR_W  read port 2 address.
- rd_data1  output  DATA_W  registered read data, port 1.
- rd_data2  output  DATA_W  registered read data, port 2.
- ready  output  1  high when in RUN (clear complete).

Behaviour:
- Reset (asynchronous, immediate):
  - state=CLEAR, clear counter=0, ready=0, rd_data1=rd_data2=0.
  - Array contents are not reset directly; the CLEAR sequence zeroes them.
- States:
  - CLEAR: each cycle writes 0 to entry[cnt], then cnt++.
  - CLEAR -> RUN: on the cycle after cnt==DEPTH-1 is written. A full clear takes exactly DEPTH cycles.
  - CLEAR behaviour: ready=0, rd_data1/2 held at 0, wr_en ignored, clr ignored.
  - RUN: ready=1, normal operation.
  - RUN -> CLEAR: clr=1 at an edge moves to CLEAR next cycle with cnt=0 and ready=0. A write presented in that same cycle is dropped.
- Write (RUN only):
  - On the edge with wr_en=1, entry[wr_addr] <= wr_data.
  - Discarded if wr_addr >= DEPTH.
  - Discarded if ZERO_REG=1 and wr_addr==0.
- Read (RUN only), one-cycle latency:
  - On each edge, rd_dataN <= entry[rd_addrN].
  - rd_dataN <= 0 if rd_addrN >= DEPTH, or if ZERO_REG=1 and rd_addrN==0.
  - Reads are always enabled; no read strobe.
- Same-edge write and read to the same address: result is defined by BR_BYPASS_EN (see Optional Feature).
- Both read ports may address the same entry; both return the same value.
- Reset asserted mid-CLEAR or mid-RUN restarts the full clear from cnt=0. Partially written data is lost.
- Counter width: clog2(DEPTH) bits, with no wrap beyond DEPTH-1.
- No X may reach rd_data1/2 after reset.

Optional Feature:
- Macro: BR_BYPASS_EN.
- Defined: write-to-read forwarding.
  - If wr_en=1 with a valid, non-discarded wr_addr equal to rd_addrN at the same edge, rd_dataN <= wr_data (new value).
- Undefined: read-before-write; rd_dataN <= old entry contents.
- Either way, the array holds wr_data after the edge.
- Discarded writes (entry 0 with ZERO_REG=1, out-of-range address) are never forwarded.

Test Plan:
- Reset and clear timing: pulse rst, DEPTH=32 -> ready=0 for 32 cycles, then 1. Reading all 32 addresses returns 0x00000000.
- Basic write/read: write 0xDEADBEEF to addr 5, then set rd_addr1=5 -> rd_data1=0xDEADBEEF exactly one cycle later. rd_data2 at addr 6 reads 0.
- Zero register: write 0x12345678 to addr 0, read addr 0 on both ports -> 0x00000000.
- Same-edge collision: addr 7 holds 0x11111111; write 0x22222222 to addr 7 while rd_addr1=7.
  - With BR_BYPASS_EN: rd_data1=0x22222222 next cycle.
  - Without BR_BYPASS_EN: rd_data1=0x11111111, then 0x22222222 one cycle later.
- clr in RUN: write 0xA5A5A5A5 to addr 3, assert clr -> ready falls next cycle and rd_data is 0 during the clear. Ready returns after 32 cycles; addr 3 then reads 0.
- Reset mid-clear and ignored writes: assert rst at clear cycle 10 -> the counter restarts and ready rises 32 cycles after release. A wr_en to addr 4 issued during CLEAR leaves addr 4 at 0.

Source files
------------

// File: rtl/regbank_sync.sv
// Clocked register bank: one synchronous write port, two registered read ports, self-clearing on reset/clr.
// Optional macro BR_BYPASS_EN forwards same-edge write data to a matching read port (default: read-before-write).
module regbank_sync #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              ready
);

    localparam int unsigned CNT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              r_ready;
    logic              w_run;
    logic              w_wr_ok;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;

    // An address is live if it is implemented and not the hardwired zero entry.
    function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    assign w_run   = (r_state == S_RUN);
    assign w_wr_ok = w_run && !clr && wr_en && addr_ok(wr_addr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_CLEAR;
            r_cnt   <= '0;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ready <= (w_state_nxt == S_RUN);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_CLEAR: begin
                if (r_cnt == CNT_W'(DEPTH - 1)) begin
                    w_state_nxt = S_RUN;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            S_RUN: begin
                if (clr) begin
                    w_state_nxt = S_CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Storage has no reset; the CLEAR walk zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (r_state == S_CLEAR) begin
            r_mem[r_cnt] <= '0;
        end else if (w_wr_ok) begin
            r_mem[CNT_W'(wr_addr)] <= wr_data;
        end
    end

    always_comb begin
        w_rd1 = addr_ok(rd_addr1) ? r_mem[CNT_W'(rd_addr1)] : '0;
        w_rd2 = addr_ok(rd_addr2) ? r_mem[CNT_W'(rd_addr2)] : '0;
`ifdef BR_BYPASS_EN
        if (w_wr_ok && (wr_addr == rd_addr1)) begin
            w_rd1 = wr_data;
        end
        if (w_wr_ok && (wr_addr == rd_addr2)) begin
            w_rd2 = wr_data;
        end
`endif
    end

    // Read data is forced to zero whenever the bank is (or is about to be) clearing.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end else if (w_run && !clr) begin
            r_rd1 <= w_rd1;
            r_rd2 <= w_rd2;
        end else begin
            r_rd1 <= '0;
            r_rd2 <= '0;
        end
    end

    assign rd_data1 = r_rd1;
    assign rd_data2 = r_rd2;
    assign ready    = r_ready;

endmodule
